// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants for the writeback scheduler: register-file geometry,
// requester slot numbering and a pointer-width helper.
package regfile_wb_sched_pkg;

    localparam int REG_COUNT   = 16;
    localparam int DEF_SEL_W   = 4;
    localparam int DEF_DATA_W  = 16;

    typedef enum int unsigned {
        WB_ALU  = 0,
        WB_LOAD = 1,
        WB_LINK = 2,
        WB_SPEC = 3
    } wb_src_e;

    // Index width that stays legal (>= 1 bit) even for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_pick.sv
// Wrapped first-set search: returns the first candidate at or after start_i,
// wrapping modulo N, ignoring any requester flagged in excl_i.
module rr_pick
    import regfile_wb_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] start_i,
    input  logic [N-1:0]     excl_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [N-1:0]     cand;
    logic [IDX_W-1:0] pos;

    assign cand = valid_i & ~excl_i;

    // Scan from the far end back towards start_i so the closest hit is written last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front; a path that skips an assignment would infer a latch.
        idx_o   = '0;
        found_o = 1'b0;
        pos     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IDX_W'((int'(start_i) + k) % N);
            if (cand[pos]) begin
                idx_o   = pos;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Round-robin writeback scheduler: grants up to two register writes per cycle
// to the dual-port register file, never targeting the same register twice.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_enable,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*SEL_W-1:0]  req_sel,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   in1_we,
    output logic [SEL_W-1:0]       in1_sel,
    output logic [DATA_W-1:0]      in1_data,
    output logic                   in2_we,
    output logic [SEL_W-1:0]       in2_sel,
    output logic [DATA_W-1:0]      in2_data,
    output logic [REG_COUNT-1:0]   pending
);

    localparam int PTR_W = idx_w(NREQ);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              in1_we_q, in1_we_d, in2_we_q, in2_we_d;
    logic [SEL_W-1:0]  in1_sel_q, in1_sel_d, in2_sel_q, in2_sel_d;
    logic [DATA_W-1:0] in1_data_q, in1_data_d, in2_data_q, in2_data_d;

    logic              grant_en;
    logic [PTR_W-1:0]  p1_idx, p2_idx;
    logic              p1_found, p2_found;
    logic [SEL_W-1:0]  p1_sel, p2_sel;
    logic [DATA_W-1:0] p1_data, p2_data;
    logic [NREQ-1:0]   p2_excl;

    // Reset outranks any request so nothing is handshaken while it is high.
    assign grant_en = wb_enable && !rst;

    rr_pick #(.N(NREQ), .IDX_W(PTR_W)) u_pick_p1 (
        .valid_i (req_valid),
        .start_i (rr_ptr_q),
        .excl_i  ({NREQ{1'b0}}),
        .idx_o   (p1_idx),
        .found_o (p1_found)
    );

    rr_pick #(.N(NREQ), .IDX_W(PTR_W)) u_pick_p2 (
        .valid_i (req_valid),
        .start_i (rr_ptr_q),
        .excl_i  (p2_excl),
        .idx_o   (p2_idx),
        .found_o (p2_found)
    );

    // Port-1 winner's fields; everyone aiming at the same register sits out port 2.
    always_comb begin
        p1_sel  = '0;
        p1_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == p1_idx) begin
                p1_sel  = req_sel[i*SEL_W +: SEL_W];
                p1_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        p2_excl = '0;
        for (int i = 0; i < NREQ; i++) begin
            p2_excl[i] = (PTR_W'(i) == p1_idx) || (req_sel[i*SEL_W +: SEL_W] == p1_sel);
        end
    end

    always_comb begin
        p2_sel  = '0;
        p2_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == p2_idx) begin
                p2_sel  = req_sel[i*SEL_W +: SEL_W];
                p2_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_en &&
                           ((p1_found && (p1_idx == PTR_W'(i))) ||
                            (p2_found && (p2_idx == PTR_W'(i))));
        end
    end

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Port 2 always lies later in scan order than port 1, so it sets the pointer when used.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        in1_we_d   = grant_en && p1_found;
        in1_sel_d  = in1_sel_q;
        in1_data_d = in1_data_q;
        in2_we_d   = grant_en && p2_found;
        in2_sel_d  = in2_sel_q;
        in2_data_d = in2_data_q;
        if (in1_we_d) begin
            in1_sel_d  = p1_sel;
            in1_data_d = p1_data;
            rr_ptr_d   = wrap_inc(p1_idx);
        end
        if (in2_we_d) begin
            in2_sel_d  = p2_sel;
            in2_data_d = p2_data;
            rr_ptr_d   = wrap_inc(p2_idx);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rr_ptr_q   <= '0;
            in1_we_q   <= 1'b0;
            in1_sel_q  <= '0;
            in1_data_q <= '0;
            in2_we_q   <= 1'b0;
            in2_sel_q  <= '0;
            in2_data_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            in1_we_q   <= in1_we_d;
            in1_sel_q  <= in1_sel_d;
            in1_data_q <= in1_data_d;
            in2_we_q   <= in2_we_d;
            in2_sel_q  <= in2_sel_d;
            in2_data_q <= in2_data_d;
        end
    end

    always_comb begin
        pending = '0;
        if (in1_we_q) pending[in1_sel_q] = 1'b1;
        if (in2_we_q) pending[in2_sel_q] = 1'b1;
    end

    assign in1_we   = in1_we_q;
    assign in1_sel  = in1_sel_q;
    assign in1_data = in1_data_q;
    assign in2_we   = in2_we_q;
    assign in2_sel  = in2_sel_q;
    assign in2_data = in2_data_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: a requester/queue model predicts grants
// and port writes; a negedge monitor pops expectations and compares.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int SW   = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wb_enable = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*SW-1:0]   req_sel = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 in1_we, in2_we;
    logic [SW-1:0]        in1_sel, in2_sel;
    logic [DW-1:0]        in1_data, in2_data;
    logic [REG_COUNT-1:0] pending;

    always #5 clk = ~clk;

    regfile_wb_sched #(.NREQ(NREQ), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_enable (wb_enable),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .req_ready (req_ready),
        .in1_we    (in1_we),
        .in1_sel   (in1_sel),
        .in1_data  (in1_data),
        .in2_we    (in2_we),
        .in2_sel   (in2_sel),
        .in2_data  (in2_data),
        .pending   (pending)
    );

    typedef struct {
        int            cyc;
        logic          we1;
        logic [SW-1:0] sel1;
        logic [DW-1:0] d1;
        logic          we2;
        logic [SW-1:0] sel2;
        logic [DW-1:0] d2;
    } port_exp_t;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] rdy;
    } rdy_exp_t;

    port_exp_t port_q[$];
    rdy_exp_t  rdy_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Requesters, each holding at most one outstanding write.
    bit            r_valid[NREQ];
    logic [SW-1:0] r_sel[NREQ];
    logic [DW-1:0] r_data[NREQ];
    bit            granted[NREQ];

    // Reference state: round-robin start, port contents, register contents.
    int            m_ptr = 0;
    port_exp_t     m_port;
    logic [DW-1:0] m_rf[REG_COUNT];
    bit            m_rf_wr[REG_COUNT];
    logic [DW-1:0] tb_rf[REG_COUNT];

    always @(posedge clk) cyc <= cyc + 1;

    // Register file downstream of the scheduler, written from the DUT ports.
    always @(posedge clk) begin
        if (in1_we === 1'b1) tb_rf[in1_sel] <= in1_data;
        if (in2_we === 1'b1) tb_rf[in2_sel] <= in2_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        rdy_exp_t        re;
        port_exp_t       pe;
        logic [REG_COUNT-1:0] pend;
        if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
            re = rdy_q.pop_front();
            check("req_ready", 64'(req_ready), 64'(re.rdy));
        end
        if (port_q.size() > 0 && port_q[0].cyc == cyc) begin
            pe = port_q.pop_front();
            pend = '0;
            if (pe.we1) pend[pe.sel1] = 1'b1;
            if (pe.we2) pend[pe.sel2] = 1'b1;
            check("in1_we",   64'(in1_we),   64'(pe.we1));
            check("in1_sel",  64'(in1_sel),  64'(pe.sel1));
            check("in1_data", 64'(in1_data), 64'(pe.d1));
            check("in2_we",   64'(in2_we),   64'(pe.we2));
            check("in2_sel",  64'(in2_sel),  64'(pe.sel2));
            check("in2_data", 64'(in2_data), 64'(pe.d2));
            check("pending",  64'(pending),  64'(pend));
        end
    end

    // Start of a cycle: requesters granted at the last edge drop their request.
    task automatic cycle_begin();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (granted[i]) r_valid[i] = 1'b0;
            granted[i] = 1'b0;
        end
    endtask

    // Drive the requester state, predict this cycle's grants and next cycle's ports.
    task automatic cycle_eval();
        int        g1, g2, idx;
        port_exp_t nxt;
        rdy_exp_t  re;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = r_valid[i];
            req_sel[i*SW +: SW]   = r_sel[i];
            req_data[i*DW +: DW]  = r_data[i];
        end
        g1 = -1;
        g2 = -1;
        if (!rst && wb_enable) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (r_valid[idx]) begin
                    if (g1 < 0) g1 = idx;
                    else if (g2 < 0 && r_sel[idx] != r_sel[g1]) g2 = idx;
                end
            end
        end
        re.cyc = cyc;
        re.rdy = '0;
        if (g1 >= 0) re.rdy[g1] = 1'b1;
        if (g2 >= 0) re.rdy[g2] = 1'b1;
        rdy_q.push_back(re);

        nxt = m_port;
        nxt.cyc = cyc + 1;
        if (rst) begin
            nxt.we1 = 1'b0; nxt.sel1 = '0; nxt.d1 = '0;
            nxt.we2 = 1'b0; nxt.sel2 = '0; nxt.d2 = '0;
            m_ptr = 0;
        end else begin
            nxt.we1 = (g1 >= 0);
            nxt.we2 = (g2 >= 0);
            if (g1 >= 0) begin
                nxt.sel1 = r_sel[g1];
                nxt.d1   = r_data[g1];
                m_rf[r_sel[g1]] = r_data[g1];
                m_rf_wr[r_sel[g1]] = 1'b1;
                granted[g1] = 1'b1;
                m_ptr = (g1 + 1) % NREQ;
            end
            if (g2 >= 0) begin
                nxt.sel2 = r_sel[g2];
                nxt.d2   = r_data[g2];
                m_rf[r_sel[g2]] = r_data[g2];
                m_rf_wr[r_sel[g2]] = 1'b1;
                granted[g2] = 1'b1;
                m_ptr = (g2 + 1) % NREQ;
            end
        end
        m_port = nxt;
        port_q.push_back(nxt);
    endtask

    task automatic run_idle(input int n);
        for (int c = 0; c < n; c++) begin
            cycle_begin();
            cycle_eval();
        end
    endtask

    task automatic set_req(input int i, input logic [SW-1:0] sel, input logic [DW-1:0] data);
        r_valid[i] = 1'b1;
        r_sel[i]   = sel;
        r_data[i]  = data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            r_valid[i] = 1'b0; r_sel[i] = '0; r_data[i] = '0; granted[i] = 1'b0;
        end
        for (int r = 0; r < REG_COUNT; r++) begin
            m_rf[r] = '0; m_rf_wr[r] = 1'b0; tb_rf[r] = '0;
        end
        m_port = '{cyc: 0, we1: 1'b0, sel1: '0, d1: '0, we2: 1'b0, sel2: '0, d2: '0};

        // Reset with every requester pending; first grants after release are req0/req1.
        rst = 1'b1;
        wb_enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle_begin();
            if (c == 0) for (int i = 0; i < NREQ; i++) set_req(i, SW'(i + 1), DW'(16'h1000 + i));
            cycle_eval();
        end
        cycle_begin();
        rst = 1'b0;
        cycle_eval();
        run_idle(4);

        // Single request from the link unit, read back two cycles after the grant.
        cycle_begin();
        set_req(int'(WB_LINK), 4'd1, 16'hDEAD);
        cycle_eval();
        run_idle(1);
        cycle_begin();
        check("readback_r1", 64'(tb_rf[1]), 64'(16'hDEAD));
        cycle_eval();
        run_idle(2);

        // Dual grant and round robin from a freshly reset pointer.
        cycle_begin();
        rst = 1'b1;
        cycle_eval();
        cycle_begin();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, SW'(i + 1), DW'(16'hBEEF + i));
        cycle_eval();
        run_idle(4);

        // Same-register conflict: req1 loses port 2 to req2 and follows next cycle.
        cycle_begin();
        set_req(0, 4'd5, 16'hA000);
        set_req(1, 4'd5, 16'hA001);
        set_req(2, 4'd6, 16'hA002);
        cycle_eval();
        run_idle(4);

        // Stall with req1 waiting, then release.
        for (int c = 0; c < 3; c++) begin
            cycle_begin();
            wb_enable = 1'b0;
            if (c == 0) set_req(1, 4'd9, 16'h5151);
            cycle_eval();
        end
        cycle_begin();
        wb_enable = 1'b1;
        cycle_eval();
        run_idle(3);

        // Reset in the cycle after a dual grant.
        cycle_begin();
        for (int i = 0; i < NREQ; i++) set_req(i, SW'(i + 10), DW'(16'h7700 + i));
        cycle_eval();
        cycle_begin();
        rst = 1'b1;
        cycle_eval();
        cycle_begin();
        rst = 1'b0;
        cycle_eval();
        run_idle(5);

        // Randomized traffic with occasional stalls and resets.
        for (int c = 0; c < 3000; c++) begin
            cycle_begin();
            rst       = ($urandom_range(0, 99) == 0);
            wb_enable = ($urandom_range(0, 99) < 85);
            for (int i = 0; i < NREQ; i++) begin
                if (!r_valid[i] && $urandom_range(0, 99) < 60) begin
                    if (c % 500 < 250) set_req(i, SW'($urandom_range(0, 3)), DW'($urandom));
                    else               set_req(i, SW'($urandom_range(0, 15)), DW'($urandom));
                end
            end
            cycle_eval();
        end
        cycle_begin();
        rst = 1'b0;
        wb_enable = 1'b1;
        cycle_eval();
        run_idle(10);

        cycle_begin();
        @(negedge clk);
        #1;
        check("port_q_drained", 64'(port_q.size()), 64'd0);
        check("rdy_q_drained",  64'(rdy_q.size()),  64'd0);
        for (int r = 0; r < REG_COUNT; r++) begin
            if (m_rf_wr[r]) check($sformatf("regfile_r%0d", r), 64'(tb_rf[r]), 64'(m_rf[r]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Writeback scheduler for the 16×16-bit dual-write-port register file. It accepts register-write requests from up to `NREQ` producers (ALU, load unit, PC/link, special-register unit) over a valid/ready handshake. Each cycle it grants at most two requests, using round-robin priority. It drives the regfile's two write ports from registered outputs and guarantees that both ports never target the same register in the same cycle.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `DATA_W`, 16: register data width.
- `SEL_W`, 4: register select width.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `wb_enable`, in, 1: when low, no grants are issued (pipeline stall).
- `req_valid`, in, `NREQ`: requester i has a write pending.
- `req_sel`, in, `NREQ*SEL_W`: target register. Requester i occupies bits `[i*SEL_W +: SEL_W]`.
- `req_data`, in, `NREQ*DATA_W`: write data. Requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready`, out, `NREQ`: grant, combinational. A transfer happens when valid and ready are both high at the edge.
- `in1_we`, out, 1: regfile write port 1 enable.
- `in1_sel`, out, `SEL_W`: write port 1 select.
- `in1_data`, out, `DATA_W`: write port 1 data.
- `in2_we`, out, 1: regfile write port 2 enable.
- `in2_sel`, out, `SEL_W`: write port 2 select.
- `in2_data`, out, `DATA_W`: write port 2 data.
- `pending`, out, 16: one-hot OR of the registers currently being written by the port outputs; consumed by the hazard logic.

## Operation
- **State:**
  - `rr_ptr` (`$clog2(NREQ)` bits).
  - Port-1 output register (we, sel, data).
  - Port-2 output register (we, sel, data).
- **Scan order.** Requesters are scanned starting at `rr_ptr`: `rr_ptr`, `rr_ptr+1`, …, wrapping modulo `NREQ`.
- **Port 1 grant.** The first valid requester in scan order is granted to port 1.
- **Port 2 grant.** The next valid requester in scan order whose `sel` differs from port 1's `sel` is granted to port 2.
  - A skipped requester with the same `sel` is not granted and keeps waiting.
  - Requesters after a skipped one remain eligible for port 2.
- **Ready.** `req_ready[i]` is high only for the granted requesters. Ready depends on the current `req_valid`, `req_sel`, `rr_ptr` and `wb_enable`. It does not depend on `req_data`.
- **Port registers on the edge.**
  - A granted port loads we=1 with the granted sel/data.
  - An ungranted port loads we=0; its sel/data hold their previous values.
- **Pointer update.**
  - With one or more grants, `rr_ptr` becomes (index of the last granted requester in scan order + 1) mod `NREQ`.
  - With no grants, `rr_ptr` is unchanged.
- **Stall.** `wb_enable`=0 means no grants: all ready bits are 0, both we are 0 next cycle, and `rr_ptr` holds.
- **Requester rules.**
  - Requesters must hold valid/sel/data stable until they are granted.
  - A requester may present a new request in the cycle after its grant.
- **`pending`.** Bit `in1_sel` is set when `in1_we`; bit `in2_sel` is set when `in2_we`.
- **Reset (`rst`=1 at an edge):**
  - `rr_ptr`=0.
  - `in1_we`=`in2_we`=0; sel=0; data=0.
  - `pending`=0.
  - While `rst` is high, `req_ready` is forced to 0. Requests in flight are dropped, and requesters re-present them after reset.

## Timing
- Grant is combinational in cycle N. The regfile port is driven in cycle N+1. The regfile commits at the edge ending N+1, so data is readable from cycle N+2.
- Throughput: 2 writes/cycle sustained when targets differ.
- No combinational path from `req_data` to `req_ready`.
- When `rst` and valid requests coincide, `rst` wins.
- With `NREQ`=1, port 2 is never used.

## Structure
- Shared include `components/hlcpu_defs.vh`: `REG_COUNT`=16, `SEL_W`=4, `DATA_W`=16, and the requester index constants (`WB_ALU`=0, `WB_LOAD`=1, `WB_LINK`=2, `WB_SPEC`=3).
- One sub-module, `rr_pick`: given a valid mask, a start pointer and an exclusion mask, it returns the first set index in wrapped order plus a found flag. It is instantiated twice: for port 1, and for port 2 with the port-1 winner and same-sel requesters masked off.

## Test plan
- **Reset.** Assert `rst` with all valid. Require: `req_ready`=0, then `in1_we`=`in2_we`=0, `pending`=0, and first grants go to req0/req1 after release.
- **Single request.** req2 valid, sel=1, data=DEAD. Require: ready[2]=1 for one cycle, next cycle `in1_we`=1/sel=1/data=DEAD, `in2_we`=0, `pending`=0x0002, and a regfile readback of DEAD two cycles after the grant.
- **Dual grant and round-robin.** All four valid, sel=1,2,3,4, data=BEEF+i, `rr_ptr`=0. Require:
  - cycle 1: req0→port1, req1→port2;
  - cycle 2: req2/req3;
  - `rr_ptr` returns to 0;
  - each requester is granted exactly once.
- **Same-register conflict.** req0 and req1 both sel=5, req2 sel=6. Require: port1=req0, port2=req2, req1 waits and is granted the following cycle.
- **Stall.** `wb_enable`=0 for 3 cycles with req1 valid. Require: ready=0, we=0, and `rr_ptr` holds. Release: req1 is granted on the first enabled cycle.
- **Reset mid-burst.** Assert `rst` in the cycle after a dual grant. Require: both we=0 on the next edge, and `rr_ptr`=0.
